// File: rtl/stride_perm_unit_if.sv
// Stream bus for stride_perm_unit: input beats with a stage select, plus the
// registered output beats (no backpressure on the output side).
interface stride_perm_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 32,
   parameter int SEL_W      = $clog2($clog2(LANES)) + 1
);
   logic [SEL_W-1:0]            stage_sel;
   logic                        in_valid;
   logic                        in_ready;
   logic [LANES*DATA_WIDTH-1:0] in_data;
   logic                        out_valid;
   logic [LANES*DATA_WIDTH-1:0] out_data;

   modport master (
      output stage_sel, in_valid, in_data,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  stage_sel, in_valid, in_data,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/stride_perm_unit.sv
// Registered stride-permutation stage: intra-beat adjacent lane-bit swap or
// inter-beat top-lane-bit/beat-parity swap. Define STRIDE_PERM_ERR_EN for the sticky err output.
module stride_perm_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 32,
   parameter int SEL_W      = $clog2($clog2(LANES)) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   stride_perm_unit_if.slave       bus
`ifdef STRIDE_PERM_ERR_EN
   ,
   output logic                    err
`endif
);

   localparam int L  = $clog2(LANES);
   localparam int H  = LANES / 2;
   localparam int W  = LANES * DATA_WIDTH;
   localparam int HW = H * DATA_WIDTH;
   localparam logic [SEL_W-1:0] SEL_INTER = SEL_W'(L - 1);

   typedef enum logic [1:0] {IDLE, HOLD_A, DRAIN_B} state_t;

   state_t         state_q, state_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   out_data_q, out_data_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   pend_q, pend_d;
   logic           accept;
   logic           is_inter;

   // Swap bits s and s+1 of the lane index; any s outside 0..L-2 is identity.
   function automatic logic [W-1:0] intra_perm(input logic [W-1:0]     d,
                                               input logic [SEL_W-1:0] s);
      intra_perm = d;
      for (int k = 0; k < L - 1; k++) begin
         if (s == SEL_W'(k)) begin
            for (int j = 0; j < LANES; j++) begin
               int b0, b1, src;
               b0  = (j >> k) & 1;
               b1  = (j >> (k + 1)) & 1;
               src = (b0 != b1) ? (j ^ (3 << k)) : j;
               intra_perm[j*DATA_WIDTH +: DATA_WIDTH] = d[src*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   endfunction

   assign is_inter = (bus.stage_sel == SEL_INTER);
   assign accept   = bus.in_valid & bus.in_ready;

   // The output register is busy with B' in DRAIN_B, so only a new A may enter.
   always_comb begin
      bus.in_ready = !((state_q == DRAIN_B) && !is_inter);
   end

   // NOTE: every always_comb target gets a default first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      a_d         = a_q;
      pend_d      = pend_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_inter) begin
                  a_d     = bus.in_data;
                  state_d = HOLD_A;
               end else begin
                  out_valid_d = 1'b1;
                  out_data_d  = intra_perm(bus.in_data, bus.stage_sel);
               end
            end
         end
         HOLD_A: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_data_d  = {bus.in_data[HW-1:0], a_q[HW-1:0]};
               pend_d      = {bus.in_data[W-1:HW], a_q[W-1:HW]};
               state_d     = DRAIN_B;
            end
         end
         DRAIN_B: begin
            out_valid_d = 1'b1;
            out_data_d  = pend_q;
            if (accept) begin
               a_d     = bus.in_data;
               state_d = HOLD_A;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // NOTE: the A and B' buffers are not reset; they are only read after being written in the current pair.
   always_ff @(posedge clk) begin
      a_q    <= a_d;
      pend_q <= pend_d;
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

`ifdef STRIDE_PERM_ERR_EN
   logic [SEL_W-1:0] sel_q;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (accept && (state_q != HOLD_A)) sel_q <= bus.stage_sel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept && (((state_q == HOLD_A) && (bus.stage_sel != sel_q)) ||
                              (bus.stage_sel >= SEL_W'(L)))) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_stride_perm_unit.sv
// Directed bench for stride_perm_unit (LANES=8, DATA_WIDTH=16, lane value = element index)
// with a cycle-stamped scoreboard of expected output beats.
module tb_stride_perm_unit;
   localparam int DW    = 16;
   localparam int LANES = 8;
   localparam int W     = DW * LANES;

   typedef logic [W-1:0] beat_t;
   typedef struct {
      beat_t data;
      int    cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
`ifdef STRIDE_PERM_ERR_EN
   logic err;
`endif

   always #5 clk = ~clk;

   stride_perm_unit_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus ();

   stride_perm_unit #(.DATA_WIDTH(DW), .LANES(LANES)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef STRIDE_PERM_ERR_EN
      ,
      .err (err)
`endif
   );

   exp_t  scoreboard[$];
   beat_t last_out;
   int    cyc   = 0;
   int    tests = 0;
   int    fails = 0;

   task automatic check(input string tag, input beat_t obs, input beat_t exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk_beat(input int base);
      beat_t r;
      for (int j = 0; j < LANES; j++) r[j*DW +: DW] = 16'(base + j);
      return r;
   endfunction

   function automatic beat_t pack(input int v[8]);
      beat_t r;
      for (int j = 0; j < LANES; j++) r[j*DW +: DW] = 16'(v[j]);
      return r;
   endfunction

   function automatic beat_t model_intra(input beat_t d, input int s);
      beat_t      r;
      logic [2:0] jb, sbits;
      for (int j = 0; j < LANES; j++) begin
         jb    = 3'(j);
         sbits = jb;
         if (s <= 1) begin
            sbits[s]     = jb[s+1];
            sbits[s + 1] = jb[s];
         end
         r[j*DW +: DW] = d[int'(sbits)*DW +: DW];
      end
      return r;
   endfunction

   // Output beat ob of a pair: global index bits 2 and 3 exchanged.
   function automatic beat_t model_inter(input beat_t a, input beat_t b, input int ob);
      beat_t      r;
      logic [3:0] g, src;
      for (int j = 0; j < LANES; j++) begin
         g      = 4'(ob * LANES + j);
         src    = g;
         src[2] = g[3];
         src[3] = g[2];
         r[j*DW +: DW] = src[3] ? b[int'(src[2:0])*DW +: DW] : a[int'(src[2:0])*DW +: DW];
      end
      return r;
   endfunction

   task automatic push(input beat_t d, input int delay);
      exp_t e;
      e.data = d;
      e.cyc  = cyc + delay;
      scoreboard.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.out_valid === 1'b1) begin
         if (scoreboard.size() == 0) begin
            check("spurious_out_valid", W'(bus.out_valid), W'(0));
         end else begin
            e = scoreboard.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_cycle", W'(cyc), W'(e.cyc));
            last_out = e.data;
         end
      end else begin
         check("out_hold", bus.out_data, last_out);
         if (scoreboard.size() > 0 && scoreboard[0].cyc <= cyc) begin
            e = scoreboard.pop_front();
            check("missing_out_valid", W'(bus.out_valid), W'(1));
         end
      end
   endtask

   task automatic send(input beat_t d, input int s, input logic exp_ready);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.stage_sel = 3'(s);
      #1;
      check("in_ready", W'(bus.in_ready), W'(exp_ready));
      cycle();
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      scoreboard.delete();
      last_out     = '0;
      repeat (2) cycle();
      rst = 1'b0;
      #1;
      check("rst_in_ready", W'(bus.in_ready), W'(1));
      check("rst_out_valid", W'(bus.out_valid), W'(0));
      check("rst_out_data", bus.out_data, W'(0));
`ifdef STRIDE_PERM_ERR_EN
      check("rst_err", W'(err), W'(0));
`endif
   endtask

   initial begin
      int v[8];
      beat_t a, b;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.stage_sel = '0;
      last_out      = '0;

      do_reset();

      // s = 0 and s = 1 against the literal lane orders
      v = '{0, 2, 1, 3, 4, 6, 5, 7};
      push(pack(v), 1);
      send(mk_beat(0), 0, 1'b1);
      v = '{0, 1, 4, 5, 2, 3, 6, 7};
      push(pack(v), 1);
      send(mk_beat(0), 1, 1'b1);
      push(model_intra(mk_beat(40), 1), 1);
      send(mk_beat(40), 1, 1'b1);
      idle(2);

      // Inter pairs streamed back-to-back
      send(mk_beat(0), 2, 1'b1);
      v = '{0, 1, 2, 3, 8, 9, 10, 11};
      push(pack(v), 1);
      v = '{4, 5, 6, 7, 12, 13, 14, 15};
      push(pack(v), 2);
      send(mk_beat(8), 2, 1'b1);
      send(mk_beat(16), 2, 1'b1);
      push(model_inter(mk_beat(16), mk_beat(24), 0), 1);
      push(model_inter(mk_beat(16), mk_beat(24), 1), 2);
      send(mk_beat(24), 2, 1'b1);
      idle(3);

      // Gap in HOLD_A, then an intra beat stalls one cycle behind B'
      send(mk_beat(32), 2, 1'b1);
      idle(3);
      push(model_inter(mk_beat(32), mk_beat(40), 0), 1);
      push(model_inter(mk_beat(32), mk_beat(40), 1), 2);
      send(mk_beat(40), 2, 1'b1);
      send(mk_beat(48), 0, 1'b0);
      push(model_intra(mk_beat(48), 0), 1);
      send(mk_beat(48), 0, 1'b1);
      idle(2);

      // Reset while holding A discards it
      send(mk_beat(56), 2, 1'b1);
      do_reset();
      send(mk_beat(64), 2, 1'b1);
      push(model_inter(mk_beat(64), mk_beat(72), 0), 1);
      push(model_inter(mk_beat(64), mk_beat(72), 1), 2);
      send(mk_beat(72), 2, 1'b1);
      idle(3);

      // Mismatched stage_sel on B: routing follows the A beat
`ifdef STRIDE_PERM_ERR_EN
      check("err_before", W'(err), W'(0));
`endif
      a = mk_beat(88);
      b = mk_beat(96);
      send(a, 2, 1'b1);
      push(model_inter(a, b, 0), 1);
      push(model_inter(a, b, 1), 2);
      send(b, 0, 1'b1);
`ifdef STRIDE_PERM_ERR_EN
      check("err_set", W'(err), W'(1));
`endif
      idle(3);
`ifdef STRIDE_PERM_ERR_EN
      check("err_held", W'(err), W'(1));
`endif

      // s >= L is identity with intra timing
      push(mk_beat(104), 1);
      send(mk_beat(104), 3, 1'b1);
      push(mk_beat(112), 1);
      send(mk_beat(112), 7, 1'b1);
      push(model_intra(mk_beat(120), 1), 1);
      send(mk_beat(120), 1, 1'b1);
      idle(3);
`ifdef STRIDE_PERM_ERR_EN
      check("err_sticky", W'(err), W'(1));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
